vc_dest_arbiter: RTL and testbench



---
 rtl/vc_dest_arbiter.sv | 70 +++++++
 tb/tb_vc_dest_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter: moves VC FIFO head words into two destination FIFOs, one word per cycle.
// Define VC_ARB_STRICT_PRIO_EN for fixed priority VC0>VC1>VC2>VC3; round-robin otherwise.
module vc_dest_arbiter #(
  parameter int DATA_W = 6,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [3:0]            vc_empty,
  input  logic [4*DATA_W-1:0]   vc_data,
  input  logic [1:0]            d_almost_full,
  output logic [3:0]            vc_pop,
  output logic [1:0]            d_push,
  output logic [DATA_W-1:0]     d_data,
  output logic [1:0]            grant_vc,
  output logic                  busy,
  output logic [CNT_W-1:0]      d0_cnt,
  output logic [CNT_W-1:0]      d1_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [3:0] elig;
  logic [1:0] base, sel;
  logic go;
  logic [DATA_W-1:0] word;
`ifdef VC_ARB_STRICT_PRIO_EN
  assign base = 2'd0;
`else
  logic [1:0] rr_ptr;
  assign base = rr_ptr;
  always_ff @(posedge clk)
    if (reset) rr_ptr <= 2'd0;
    else if (go) rr_ptr <= sel + 2'd1;
`endif
  // scan downward so the eligible VC closest to base wins
  always_comb begin
    for (int i = 0; i < 4; i++)
      elig[i] = !vc_empty[i] && !d_almost_full[vc_data[i*DATA_W+DATA_W-1]];
    sel = base;
    for (int k = 3; k >= 0; k--)
      if (elig[base + 2'(k)]) sel = base + 2'(k);
  end
  assign go = state == RUN && enable && |elig;
  assign word = vc_data[sel*DATA_W +: DATA_W];
  assign vc_pop = go ? 4'b0001 << sel : 4'b0000;
  assign busy = state != IDLE;
  always_comb
    state_nx = state == IDLE ? (enable ? RUN : IDLE) :
               state == RUN  ? (enable ? RUN : FLUSH) : IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      d_push <= 2'b00;
      d_data <= '0;
      grant_vc <= 2'd0;
      d0_cnt <= '0;
      d1_cnt <= '0;
    end else begin
      state <= state_nx;
      d_push <= go ? (word[DATA_W-1] ? 2'b10 : 2'b01) : 2'b00;
      if (go) begin
        d_data <= word;
        grant_vc <= sel;
      end
      d0_cnt <= d0_cnt + CNT_W'(d_push[0]);
      d1_cnt <= d1_cnt + CNT_W'(d_push[1]);
    end
  end
endmodule

// File: tb/tb_vc_dest_arbiter.sv
// tb_vc_dest_arbiter: directed plus random stimulus checked every cycle against a behavioural model.
module tb_vc_dest_arbiter;
  logic clk = 0, reset = 1, enable = 1;
  logic [3:0] vc_empty = 4'hF;
  logic [23:0] vc_data = '0;
  logic [1:0] d_almost_full = 2'b00;
  logic [3:0] vc_pop;
  logic [1:0] d_push, grant_vc;
  logic [5:0] d_data;
  logic busy;
  logic [7:0] d0_cnt, d1_cnt;
  int checks = 0, failures = 0;
  int m_state = 0, m_rr = 0, m_gnt = 0, m_c0 = 0, m_c1 = 0;
  logic [1:0] m_push = 0;
  logic [5:0] m_data = 0;

  vc_dest_arbiter dut (.clk(clk), .reset(reset), .enable(enable), .vc_empty(vc_empty),
    .vc_data(vc_data), .d_almost_full(d_almost_full), .vc_pop(vc_pop), .d_push(d_push),
    .d_data(d_data), .grant_vc(grant_vc), .busy(busy), .d0_cnt(d0_cnt), .d1_cnt(d1_cnt));

  always #5 clk = ~clk;

  // model state: 0 idle, 1 run, 2 flush
  function automatic int pick();
    int b = m_rr;
`ifdef VC_ARB_STRICT_PRIO_EN
    b = 0;
`endif
    if (m_state != 1 || !enable) return -1;
    for (int k = 0; k < 4; k++) begin
      int i = (b + k) % 4;
      if (!vc_empty[i] && !d_almost_full[vc_data[i*6+5]]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic cmp();
    int p = pick();
    chk("vc_pop", 32'(vc_pop), p < 0 ? 0 : (1 << p));
    chk("d_push", 32'(d_push), 32'(m_push));
    chk("d_data", 32'(d_data), 32'(m_data));
    chk("grant_vc", 32'(grant_vc), m_gnt);
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("d0_cnt", 32'(d0_cnt), m_c0);
    chk("d1_cnt", 32'(d1_cnt), m_c1);
  endtask

  task automatic upd();
    int p = pick();
    if (reset) begin
      m_state = 0; m_rr = 0; m_gnt = 0; m_c0 = 0; m_c1 = 0; m_push = 0; m_data = 0;
    end else begin
      m_c0 = (m_c0 + m_push[0]) % 256;
      m_c1 = (m_c1 + m_push[1]) % 256;
      m_push = 0;
      if (p >= 0) begin
        m_push = vc_data[p*6+5] ? 2'b10 : 2'b01;
        m_data = vc_data[p*6 +: 6];
        m_gnt = p;
        m_rr = (p + 1) % 4;
      end
      m_state = m_state == 0 ? (enable ? 1 : 0) : m_state == 1 ? (enable ? 1 : 2) : 0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cmp();
    @(posedge clk);
    upd();
    #1;
  endtask

  initial begin
    @(posedge clk);
    upd();
    #1;
    cyc();
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_push", 32'(d_push), 0);
    chk("rst_cnt", 32'({d0_cnt, d1_cnt}), 0);
    reset = 0;
    cyc();
    #1;
    chk("busy_after_1", 32'(busy), 1);
    chk("idle_pop", 32'(vc_pop), 0);
`ifndef VC_ARB_STRICT_PRIO_EN
    vc_empty = 4'b1010;
    vc_data = {6'd0, 6'b100011, 6'd0, 6'b000101};
    #1;
    chk("ex_pop0", 32'(vc_pop), 32'b0001);
    cyc();
    vc_empty = 4'b1110 | 4'b1011 & 4'b1011;
    vc_empty = 4'b1011;
    #1;
    chk("ex_push0", 32'(d_push), 32'b01);
    chk("ex_data0", 32'(d_data), 32'b000101);
    chk("ex_pop2", 32'(vc_pop), 32'b0100);
    cyc();
    vc_empty = 4'hF;
    #1;
    chk("ex_push1", 32'(d_push), 32'b10);
    chk("ex_data1", 32'(d_data), 32'b100011);
    chk("ex_gnt", 32'(grant_vc), 2);
    chk("ex_d0cnt", 32'(d0_cnt), 1);
    cyc();
    #1;
    chk("ex_d1cnt", 32'(d1_cnt), 1);
    vc_empty = 4'h0;
    vc_data = {6'd4, 6'd3, 6'd2, 6'd1};
    #1;
    chk("rr_first", 32'(vc_pop), 32'b1000);
    repeat (8) cyc();
    vc_empty = 4'b1100;
    vc_data = {6'd0, 6'd0, 6'b100111, 6'b001001};
    d_almost_full = 2'b01;
    #1;
    chk("af_only_vc1", 32'(vc_pop), 32'b0010);
    cyc();
    vc_empty = 4'b1110;
    #1;
    chk("af_block_vc0", 32'(vc_pop), 0);
    cyc();
    d_almost_full = 2'b00;
    #1;
    chk("af_clear_vc0", 32'(vc_pop), 32'b0001);
    cyc();
    enable = 0;
    #1;
    chk("drop_pop", 32'(vc_pop), 0);
    chk("drop_push", 32'(d_push), 32'b01);
    cyc();
    #1;
    chk("flush_busy", 32'(busy), 1);
    chk("flush_push", 32'(d_push), 0);
    cyc();
    #1;
    chk("idle_busy", 32'(busy), 0);
    enable = 1;
    cyc();
    #1;
    chk("mid_pop", 32'(vc_pop), 32'b0001);
    cyc();
    reset = 1;
    vc_empty = 4'hF;
    #1;
    chk("mid_push", 32'(d_push), 32'b01);
    cyc();
    reset = 0;
    #1;
    chk("mid_rst_push", 32'(d_push), 0);
    chk("mid_rst_cnt", 32'({d0_cnt, d1_cnt}), 0);
    cyc();
    vc_empty = 4'b1110;
    repeat (256) cyc();
    #1;
    chk("cnt_255", 32'(d0_cnt), 255);
    vc_empty = 4'hF;
    cyc();
    #1;
    chk("cnt_wrap", 32'(d0_cnt), 0);
`else
    vc_empty = 4'b0110;
    vc_data = {6'd7, 6'd0, 6'd0, 6'd5};
    repeat (10) begin
      #1;
      chk("strict_vc0", 32'(vc_pop), 32'b0001);
      cyc();
    end
`endif
    for (int n = 0; n < 2000; n++) begin
      reset = $urandom_range(0, 49) == 0;
      enable = $urandom_range(0, 9) != 0;
      vc_empty = 4'($urandom);
      vc_data = 24'($urandom);
      d_almost_full = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
